mem_req_arbiter_4: RTL
======================

// Module: mem_req_arbiter_4
// PURPOSE
// - Round-robin arbiter for four requesting cores sharing one memory port.
// - Sits directly upstream of mux_4to1: drives its 2-bit sel so the granted core's address/data reaches the shared level.
// - Holds each grant for one complete transaction, until mem_done or request withdrawal.
// PARAMETERS
// - TIMEOUT_CYCLES  64  max cycles a grant may be held in BUSY (used only with ARB_TIMEOUT_EN)
// - TO_WIDTH        7   width of timeout counter; must satisfy 2**TO_WIDTH > TIMEOUT_CYCLES
// PORTS
// - clk       in   1  system clock, all state updates on rising edge
// - rst_n     in   1  asynchronous active-low reset
// - req       in   4  per-core request, bit i = core i; level, held until served
// - mem_done  in   1  one-cycle pulse from shared memory: current transaction complete
// - grant     out  4  one-hot grant, registered; all-zero when idle
// - sel       out  2  binary index of current/last grant; feeds mux_4to1 sel
// - busy      out  1  high while a grant is held (state BUSY)
// - timeout   out  1  one-cycle pulse on forced release (ARB_TIMEOUT_EN only; else tied 0)
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, grant=4'b0000, sel=2'b00, busy=0, timeout=0,
//   last-grant pointer ptr=2'd3 (core 0 has highest priority first), counter=0.
// - States: IDLE, BUSY. Encoded in a registered state variable; no other states.
// - IDLE: if req!=0, winner = first set bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
//   Next edge: grant=onehot(winner), sel=winner, busy=1, state=BUSY. If req==0 stay IDLE.
// - Latency: req sampled high at edge k in IDLE -> grant visible after edge k (1 cycle).
// - BUSY: grant/sel held stable. Release when mem_done=1 OR req[sel]=0 (withdrawal).
//   On release edge: grant=0, busy=0, ptr=sel, state=IDLE. sel keeps last value.
// - Mandatory one idle cycle between grants (re-arbitration in IDLE); back-to-back
//   grant to the same core only if no other core requests.
// - mem_done while IDLE: ignored, no state change.
// - mem_done and withdrawal same cycle: single release, ptr updated once.
// - Multiple new reqs arriving during BUSY: queued implicitly by level req; resolved
//   by rotation at next IDLE. Fairness: any continuously asserted req is granted
//   within 4 transactions.
// - ptr wraps 3 -> 0 naturally (2-bit modulo).
// - grant is always one-hot or zero; never two bits set.
// - rst_n asserted mid-transaction: grant drops immediately (async), all state as reset.
// CONFIGURATION
// - Macro ARB_TIMEOUT_EN.
// - Defined: TO_WIDTH-bit counter clears on entry to BUSY, increments each BUSY cycle.
//   When counter reaches TIMEOUT_CYCLES-1 without release: forced release on that edge
//   (same effects as normal release, ptr=sel), timeout pulses 1 for one cycle.
//   Normal release on the same cycle takes precedence; timeout stays 0.
// - Undefined: no counter logic; timeout tied 0; grant held indefinitely until release.
// TESTING
// - Reset then req=4'b0001 -> next cycle grant=0001, sel=0, busy=1; mem_done pulse -> grant=0000, busy=0.
// - req=4'b1111 held, mem_done every BUSY cycle -> grant order 0001,0010,0100,1000,0001; one idle cycle between each.
// - Core 2 granted, req[2] dropped with mem_done=0 -> grant=0 next cycle, ptr=2, next winner core 3 if requesting.
// - ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64, req=0001, no mem_done -> release after 64 BUSY cycles, timeout=1 one cycle.
// - rst_n low during BUSY with sel=3 -> grant=0000, sel=00 immediately; after release req=1000 granted before lower cores only if core 0-2 idle.
// - mem_done pulsed in IDLE with req=0 -> no grant, busy stays 0, ptr unchanged.

Source files
------------

// File: rtl/mem_req_arbiter_4.sv
// mem_req_arbiter_4: round-robin arbiter for four cores that share one memory port.
// Each grant is held for a whole transaction, until mem_done or until the core
// withdraws its request. sel drives the downstream mux_4to1.
// Optional feature: define ARB_TIMEOUT_EN to add a watchdog that force-releases a
// grant held for TIMEOUT_CYCLES cycles and pulses timeout for one cycle.

module mem_req_arbiter_4 #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_WIDTH       = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       mem_done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state, state_next;
  logic [1:0] ptr, ptr_next;
  logic [3:0] grant_next;
  logic [1:0] sel_next;
  logic       busy_next;
  logic       timeout_next;
  logic [1:0] winner;
  logic [1:0] scan_idx;
  logic       found;
  logic       release_now;

  // The watchdog counter must be able to represent its terminal value
  if (2 ** TO_WIDTH <= TIMEOUT_CYCLES) begin : g_bad_width
    $error("TO_WIDTH too small for TIMEOUT_CYCLES");
  end

`ifdef ARB_TIMEOUT_EN
  logic [TO_WIDTH-1:0] cnt, cnt_next;
`endif

  // Rotating priority scan: ptr+1 first, ptr (last winner) last
  always_comb begin
    winner   = ptr;
    found    = 1'b0;
    scan_idx = ptr;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = ptr + 2'(i);
      if (!found && req[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  // Next-state and registered-output computation for the IDLE/BUSY machine
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    grant_next   = grant;
    sel_next     = sel;
    busy_next    = busy;
    timeout_next = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_next     = cnt;
`endif
    release_now  = mem_done || !req[sel];

    case (state)
      IDLE: begin
        if (found) begin
          state_next = BUSY;
          grant_next = 4'b0001 << winner;
          sel_next   = winner;
          busy_next  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end
      BUSY: begin
        if (release_now) begin
          state_next = IDLE;
          grant_next = 4'b0000;
          busy_next  = 1'b0;
          ptr_next   = sel;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          state_next   = IDLE;
          grant_next   = 4'b0000;
          busy_next    = 1'b0;
          ptr_next     = sel;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt + TO_WIDTH'(1);
        end
`endif
      end
      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd3;
      grant   <= 4'b0000;
      sel     <= 2'b00;
      busy    <= 1'b0;
      timeout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt     <= '0;
`endif
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      grant   <= grant_next;
      sel     <= sel_next;
      busy    <= busy_next;
      timeout <= timeout_next;
`ifdef ARB_TIMEOUT_EN
      cnt     <= cnt_next;
`endif
    end
  end

endmodule
